// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: walks a PC through instruction memory, hands words to
// decode with a valid/ready handshake, and honours control-flow redirects from next-PC.
module pc_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    output logic [31:0] fetch_count
);
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] tgt_q;
    logic        discard_q;
    logic        inst_valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic [31:0] fetch_count_q;
    logic [31:0] redirect_pc_d;

    assign redirect_pc_d = redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            tgt_q         <= RESET_PC;
            discard_q     <= 1'b0;
            inst_valid_q  <= 1'b0;
            inst_q        <= '0;
            inst_pc_q     <= '0;
            fetch_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        discard_q <= 1'b0;
                        // A fresh redirect wins over an older latched target.
                        if (redirect_valid) begin
                            pc_q <= redirect_pc_d;
                        end else if (discard_q) begin
                            pc_q <= tgt_q;
                        end else begin
                            inst_q       <= imem_rdata;
                            inst_pc_q    <= pc_q;
                            pc_q         <= pc_q + 32'd4;
                            inst_valid_q <= 1'b1;
                            state_q      <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Request in flight keeps its address; remember where to go after it.
                        discard_q <= 1'b1;
                        tgt_q     <= redirect_pc_d;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        fetch_count_q <= fetch_count_q + 32'd1;
                        inst_valid_q  <= 1'b0;
                        state_q       <= FETCH;
                        if (redirect_valid) pc_q <= redirect_pc_d;
                    end else if (redirect_valid) begin
                        inst_valid_q <= 1'b0;
                        pc_q         <= redirect_pc_d;
                        state_q      <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_pc4    = inst_pc_q + 32'd4;
    assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, all checked against a
// transaction-level fetch model kept here.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic [31:0] fetch_count;

    int n_chk = 0;
    int n_pass = 0;

    // Model: started -> fetching unless an instruction is held; pending redirect target.
    bit          m_started, m_valid, m_pend;
    logic [31:0] m_pc, m_tgt, m_inst, m_ipc, m_cnt;

    pc_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    endtask

    task automatic m_reset();
        m_started = 0; m_valid = 0; m_pend = 0;
        m_pc = 32'h3000; m_tgt = 32'h3000;
        m_inst = 0; m_ipc = 0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        chk("req", {31'd0, imem_req}, {31'd0, m_started && !m_valid});
        if (m_started && !m_valid) chk("addr", imem_addr, m_pc);
        chk("valid", {31'd0, inst_valid}, {31'd0, m_valid});
        chk("inst", inst, m_inst);
        chk("inst_pc", inst_pc, m_ipc);
        chk("inst_pc4", inst_pc4, m_ipc + 32'd4);
        chk("count", fetch_count, m_cnt);
    endtask

    // One clock: check at negedge, drive, let the edge happen, advance the model.
    task automatic cyc(input bit ack, input bit rdy, input bit rv, input logic [31:0] rpc);
        logic [31:0] rd, al;
        rd = $urandom;
        al = rpc & 32'hFFFF_FFFC;
        check_outputs();
        imem_ack = ack; inst_ready = rdy; redirect_valid = rv;
        redirect_pc = rpc; imem_rdata = rd;
        @(posedge clk);
        if (!m_started) begin
            m_started = 1;
        end else if (!m_valid) begin
            if (ack) begin
                if (rv) m_pc = al;
                else if (m_pend) m_pc = m_tgt;
                else begin
                    m_valid = 1; m_inst = rd; m_ipc = m_pc; m_pc = m_pc + 32'd4;
                end
                m_pend = 0;
            end else if (rv) begin
                m_pend = 1; m_tgt = al;
            end
        end else begin
            if (rdy) m_cnt = m_cnt + 32'd1;
            if (rdy || rv) m_valid = 0;
            if (rv) m_pc = al;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h3000);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_ipc"}, inst_pc, 32'd0);
        chk({tag, "_ipc4"}, inst_pc4, 32'd4);
        chk({tag, "_cnt"}, fetch_count, 32'd0);
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset_n = 1'b1;

        // Sequential fetch, memory acks immediately, decode always ready.
        repeat (7) cyc(1, 1, 0, 0);
        chk("seq_cnt", fetch_count, 32'd3);

        // Backpressure in HOLD.
        cyc(1, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 0);
        chk("bp_cnt", fetch_count, 32'd3);
        cyc(0, 1, 0, 0);
        chk("bp_rel_cnt", fetch_count, 32'd4);

        // Redirect two cycles before the ack.
        cyc(0, 0, 1, 32'h3100);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("mid_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_addr", imem_addr, 32'h3100);

        // Redirect with ack, then redirect with handshake.
        cyc(1, 0, 1, 32'h3200);
        chk("co_ack_addr", imem_addr, 32'h3200);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 32'h3200);
        chk("co_hs_addr", imem_addr, 32'h3200);

        // Unaligned target near the top of memory, then wrap to zero.
        cyc(0, 0, 1, 32'hFFFF_FFFE);
        cyc(1, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0);
        chk("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_ipc4", inst_pc4, 32'd0);
        cyc(0, 1, 0, 0);
        chk("wrap_next", imem_addr, 32'd0);

        // Asynchronous reset while a discarded request is outstanding.
        cyc(0, 0, 1, 32'h4440);
        #2 reset_n = 1'b0;
        #1 check_reset_values("amid");
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h5550;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("hold");
        imem_ack = 1'b0; redirect_valid = 1'b0;
        reset_n = 1'b1;
        m_reset();
        repeat (3) cyc(1, 1, 0, 0);
        chk("post_rst_ipc", inst_pc, 32'h3000);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 4) < 3,
                $urandom_range(0, 9) == 0, rpc);
        end
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
